// File: rtl/lc3_dmem_responder_if.sv
// LC3 data-memory port: request/response signals between initiator and responder.
interface lc3_dmem_responder_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic              dmem_req;
    logic              Data_rd;
    logic [ADDR_W-1:0] Data_addr;
    logic [DATA_W-1:0] Data_din;
    logic [DATA_W-1:0] Data_dout;
    logic              complete_data;
    logic              addr_err;
    logic              busy;

    // Initiator side
    modport master (
        output dmem_req, Data_rd, Data_addr, Data_din,
        input  Data_dout, complete_data, addr_err, busy
    );

    // Responder side
    modport slave (
        input  dmem_req, Data_rd, Data_addr, Data_din,
        output Data_dout, complete_data, addr_err, busy
    );
endinterface

// File: rtl/lc3_dmem_responder.sv
// LC3 data-memory responder: wait-state latency, one-cycle completion strobe,
// out-of-range detection and a side-band preload port.
// Optional macro LC3_DMEM_STATS_EN adds saturating rd/wr/err counters.
module lc3_dmem_responder #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    lc3_dmem_responder_if.slave   bus,
    input  logic                  init_we,
    input  logic [DEPTH_LOG2-1:0] init_addr,
    input  logic [DATA_W-1:0]     init_data
`ifdef LC3_DMEM_STATS_EN
    ,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
    output logic [7:0]            err_count
`endif
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam bit          NO_WAIT = (WAIT_CYCLES == 0);

    // Counter is only 4 bits wide; reject configurations it cannot hold
    if (WAIT_CYCLES > 15) begin : g_wait_range
        $error("lc3_dmem_responder: WAIT_CYCLES must be in 0..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   din_q;
    logic                rd_q;
    logic                latch_c;
    logic                req_rd_c;
    logic [ADDR_W-1:0]   req_addr_c;
    logic                req_oor_c;
    logic                oor_q_c;
    logic                enter_resp_c;
    logic [DATA_W-1:0]   rd_data_c;
    logic [DATA_W-1:0]   dout_q;
    logic                complete_q;
    logic                addr_err_q;
    logic                busy_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Next-state logic plus the request view seen on the edge into RESP
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        latch_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dmem_req) begin
                    latch_c = 1'b1;
                    if (NO_WAIT) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // With zero wait states RESP is entered on the accepting edge itself,
        // so the live bus fields stand in for the not-yet-latched copies
        req_rd_c     = latch_c ? bus.Data_rd   : rd_q;
        req_addr_c   = latch_c ? bus.Data_addr : addr_q;
        req_oor_c    = (req_addr_c >> DEPTH_LOG2) != '0;
        oor_q_c      = (addr_q >> DEPTH_LOG2) != '0;
        enter_resp_c = (state_d == RESP);

        // A same-cycle preload to the read address wins, as the array
        // is conceptually read after the preload lands
        if (state_q == IDLE && init_we && init_addr == req_addr_c[DEPTH_LOG2-1:0]) begin
            rd_data_c = init_data;
        end else begin
            rd_data_c = mem[req_addr_c[DEPTH_LOG2-1:0]];
        end
    end

    // State, counter, latched request and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            rd_q       <= 1'b0;
            dout_q     <= '0;
            complete_q <= 1'b0;
            addr_err_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            if (latch_c) begin
                addr_q <= bus.Data_addr;
                din_q  <= bus.Data_din;
                rd_q   <= bus.Data_rd;
            end
            complete_q <= enter_resp_c;
            addr_err_q <= enter_resp_c && req_oor_c;
            busy_q     <= (state_d != IDLE);
            if (enter_resp_c && req_rd_c) begin
                dout_q <= req_oor_c ? '0 : rd_data_c;
            end
        end
    end

    // Array: preload in IDLE, request write on the edge leaving RESP; never reset
    always_ff @(posedge clock) begin
        if (state_q == IDLE && init_we) begin
            mem[init_addr] <= init_data;
        end else if (state_q == RESP && !rd_q && !oor_q_c) begin
            mem[addr_q[DEPTH_LOG2-1:0]] <= din_q;
        end
    end

`ifdef LC3_DMEM_STATS_EN
    // Saturating transaction statistics, counted in the RESP cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_count  <= '0;
            wr_count  <= '0;
            err_count <= '0;
        end else if (state_q == RESP) begin
            if (rd_q && rd_count != '1) begin
                rd_count <= rd_count + 16'(1);
            end
            if (!rd_q && wr_count != '1) begin
                wr_count <= wr_count + 16'(1);
            end
            if (oor_q_c && err_count != '1) begin
                err_count <= err_count + 8'(1);
            end
        end
    end
`endif

    assign bus.Data_dout     = dout_q;
    assign bus.complete_data = complete_q;
    assign bus.addr_err      = addr_err_q;
    assign bus.busy          = busy_q;

endmodule

// File: doc/lc3_dmem_responder.md
Name: lc3_dmem_responder

Overview:
- Synthesizable data-memory responder for the LC3 data-memory port.
- Answers the initiator's read/write requests with a programmable wait-state latency and a one-cycle completion strobe.
- Used in place of the behavioural dmem agent for standalone RTL and emulation runs.
- Includes a side-band preload port so benches can initialise memory contents before the program runs.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, request address width.
- DEPTH_LOG2, 10, log2 of implemented words (1024). Addresses at or above 2^DEPTH_LOG2 are out of range.
- WAIT_CYCLES, 2, extra wait states between accept and completion. Legal range 0..15.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dmem_req  in  1  request strobe, sampled only in IDLE.
- Data_rd  in  1  1 = read, 0 = write; qualified by dmem_req.
- Data_addr  in  ADDR_W  request address.
- Data_din  in  DATA_W  write data from the initiator.
- Data_dout  out  DATA_W  read data returned to the initiator.
- complete_data  out  1  one-cycle completion pulse.
- addr_err  out  1  pulses with complete_data when the address is out of range.
- busy  out  1  high in WAIT and RESP.
- init_we  in  1  preload write enable.
- init_addr  in  DEPTH_LOG2  preload address.
- init_data  in  DATA_W  preload data.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FSM goes to IDLE; complete_data, addr_err and busy = 0; Data_dout = 0; wait counter = 0.
  - Memory array is not cleared; its contents are preserved across reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - On dmem_req=1, latch Data_addr, Data_din and Data_rd into internal registers.
  - If WAIT_CYCLES=0, go to RESP. Otherwise go to WAIT with counter = WAIT_CYCLES.
- WAIT: counter decrements each cycle. When counter = 1, go to RESP next.
- RESP:
  - complete_data = 1 for exactly this cycle, then return to IDLE unconditionally.
  - Read: Data_dout is loaded with mem[addr_q] on the edge entering RESP, so data is valid while complete_data is high. Data_dout then holds until the next read completes; writes never change it.
  - Write: mem[addr_q] <= din_q on the edge leaving RESP.
- Latency: complete_data is high in cycle N+1+WAIT_CYCLES for a request sampled at edge N.
- Throughput: minimum spacing between accepted requests is WAIT_CYCLES+2 cycles.
- dmem_req in WAIT or RESP is ignored and not queued. A request held high through RESP is re-accepted as a new request on the first IDLE cycle, so the initiator must drop dmem_req on seeing complete_data.
- Out of range (addr_q[ADDR_W-1:DEPTH_LOG2] != 0):
  - Read returns 0 in Data_dout.
  - Write is dropped; the array is unchanged.
  - addr_err = 1 in the RESP cycle.
  - Latency is unchanged.
- Preload:
  - init_we is honoured only in IDLE, where mem[init_addr] <= init_data.
  - init_we in WAIT or RESP is ignored.
  - init_we and dmem_req together in IDLE: both are performed. A read of the same address returns init_data because the array is read later, on the edge into RESP.
- Reset mid-operation: the pending request is discarded with no completion pulse and no array write.
- WAIT_CYCLES > 15 is flagged by an elaboration-time error.

Optional Feature:
- Macro: LC3_DMEM_STATS_EN.
- Defined:
  - Adds outputs rd_count (16), wr_count (16) and err_count (8).
  - rd_count / wr_count increment in each RESP cycle of a read / write.
  - err_count increments on each addr_err. All three counters saturate at their maximum value.
  - All three reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- WAIT_CYCLES=2, preload mem[0x0010]=0xBEEF, read 0x0010 sampled at edge 5 -> complete_data high only in cycle 8, Data_dout=0xBEEF, addr_err=0.
- Write 0x1234 to 0x0020, then read 0x0020 -> read returns 0x1234; Data_dout unchanged by the write and still holds the previous read value.
- WAIT_CYCLES=0, dmem_req held high for 6 cycles -> complete_data pulses every 2 cycles (3 pulses); busy alternates.
- Read address 0x0400 with DEPTH_LOG2=10 -> Data_dout=0x0000, addr_err=1 with complete_data; a write to 0x0400 leaves mem[0x0000] unchanged.
- reset_n low for 1 cycle during WAIT of a write to 0x0030 (old value 0x5555) -> no complete_data, mem[0x0030] still 0x5555, all outputs 0.
- LC3_DMEM_STATS_EN defined: 3 reads, 2 writes, 1 out-of-range read -> rd_count=4, wr_count=2, err_count=1.
